// File: rtl/instr_line_packer_pkg.sv
// Shared constants and state type for the instruction-line packer.
package instr_packer_pkg;

   localparam int LINEW = 512;
   localparam int DATAW = 32;
   localparam int WORDS = LINEW / DATAW;
   localparam int LVL_W = $clog2(WORDS + 1);
   localparam logic [DATAW-1:0] PAD_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      FILL,
      HOLD,
      PULSE
   } packer_state_t;

endpackage

// File: rtl/instr_line_packer.sv
// Packs DATAW-bit instruction words into LINEW-bit lines and strobes them into the CPU.
// Optional line_checksum output is enabled by defining INSTR_PACKER_CHECKSUM_EN.
//
// state | meaning
// FILL  | accepting words into lanes, flush may close a partial line
// HOLD  | line complete, waiting for cache_stall to drop
// PULSE | instr_write_en high for this single cycle
module instr_line_packer
   import instr_packer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATAW-1:0]  word_in,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic              flush,
   input  logic              cache_stall,
   output logic [LINEW-1:0]  line_out,
   output logic              instr_write_en,
   output logic [LVL_W-1:0]  fill_level,
`ifdef INSTR_PACKER_CHECKSUM_EN
   output logic [DATAW-1:0]  line_checksum,
`endif
   output logic [15:0]       line_count
);

   packer_state_t     state_q, state_d;
   logic [LINEW-1:0]  line_q, line_d;
   logic              wen_q, wen_d;
   logic              ready_q, ready_d;
   logic [LVL_W-1:0]  fill_q, fill_d;
   logic [15:0]       count_q, count_d;
`ifdef INSTR_PACKER_CHECKSUM_EN
   logic [DATAW-1:0]  csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      fill_d  = fill_q;
      count_d = count_q;
`ifdef INSTR_PACKER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         FILL: begin
            if (word_valid && ready_q) begin
               for (int i = 0; i < WORDS; i++) begin
                  if (fill_q == LVL_W'(i)) line_d[i*DATAW +: DATAW] = word_in;
               end
`ifdef INSTR_PACKER_CHECKSUM_EN
               csum_d = csum_d ^ word_in;
`endif
               fill_d = fill_q + LVL_W'(1);
            end
            // A word landing in the last lane wins over flush: plain completion.
            if (fill_d == LVL_W'(WORDS)) begin
               state_d = HOLD;
            end else if (flush && (fill_d != '0)) begin
               for (int i = 0; i < WORDS; i++) begin
                  if (LVL_W'(i) >= fill_d) begin
                     line_d[i*DATAW +: DATAW] = PAD_WORD;
`ifdef INSTR_PACKER_CHECKSUM_EN
                     csum_d = csum_d ^ PAD_WORD;
`endif
                  end
               end
               fill_d  = LVL_W'(WORDS);
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!cache_stall) begin
               state_d = PULSE;
               count_d = count_q + 16'd1;
            end
         end
         PULSE: begin
            state_d = FILL;
            fill_d  = '0;
`ifdef INSTR_PACKER_CHECKSUM_EN
            csum_d  = '0;
`endif
         end
         default: state_d = FILL;
      endcase
      wen_d   = (state_d == PULSE);
      ready_d = (state_d == FILL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         line_q  <= '0;
         wen_q   <= 1'b0;
         ready_q <= 1'b1;
         fill_q  <= '0;
         count_q <= '0;
`ifdef INSTR_PACKER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         wen_q   <= wen_d;
         ready_q <= ready_d;
         fill_q  <= fill_d;
         count_q <= count_d;
`ifdef INSTR_PACKER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign word_ready     = ready_q;
   assign line_out       = line_q;
   assign instr_write_en = wen_q;
   assign fill_level     = fill_q;
   assign line_count     = count_q;
`ifdef INSTR_PACKER_CHECKSUM_EN
   assign line_checksum  = csum_q;
`endif

endmodule

// File: tb/tb_instr_line_packer.sv
// Scoreboard bench for instr_line_packer: a word-queue model predicts each delivered line.
module tb_instr_line_packer;
   import instr_packer_pkg::*;

   logic              clk;
   logic              rst;
   logic [DATAW-1:0]  word_in;
   logic              word_valid;
   logic              word_ready;
   logic              flush;
   logic              cache_stall;
   logic [LINEW-1:0]  line_out;
   logic              instr_write_en;
   logic [LVL_W-1:0]  fill_level;
   logic [15:0]       line_count;
`ifdef INSTR_PACKER_CHECKSUM_EN
   logic [DATAW-1:0]  line_checksum;
`endif

   instr_line_packer dut (
      .clk            (clk),
      .rst            (rst),
      .word_in        (word_in),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .flush          (flush),
      .cache_stall    (cache_stall),
      .line_out       (line_out),
      .instr_write_en (instr_write_en),
      .fill_level     (fill_level),
`ifdef INSTR_PACKER_CHECKSUM_EN
      .line_checksum  (line_checksum),
`endif
      .line_count     (line_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   logic [DATAW-1:0] cur[$];
   logic [LINEW-1:0] exp_q[$];
   int               model_lines = 0;
   int               pulses = 0;
   int unsigned      pulse_cyc = 0;
   logic [LINEW-1:0] last_line = '0;
   bit               chk_fill0 = 0;
   bit               rand_stall = 0;
   int unsigned      last_acc = 0;

   task automatic check(input string name, input logic [LINEW-1:0] act, input logic [LINEW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Close the current partial line: accepted words in order, pad words after.
   task automatic close_line();
      logic [LINEW-1:0] l;
      l = '0;
      for (int k = 0; k < WORDS; k++)
         l[k*DATAW +: DATAW] = (k < cur.size()) ? cur[k] : PAD_WORD;
      exp_q.push_back(l);
      cur.delete();
      model_lines++;
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_stall) cache_stall = ($urandom_range(0, 2) == 0);
   endtask

   task automatic put(input logic [DATAW-1:0] w, input bit fl);
      int n;
      n = 0;
      word_valid = 1'b1;
      word_in    = w;
      flush      = fl;
      while (!word_ready && n < 300) begin
         tick();
         n++;
      end
      check("ready_wait", word_ready, 1);
      if (word_ready) begin
         cur.push_back(w);
         if (cur.size() == WORDS) close_line();
         else if (fl) close_line();
         last_acc = cyc + 1;
         @(posedge clk);
      end else begin
         word_valid = 1'b0;
      end
      tick();
   endtask

   task automatic idle();
      word_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic do_flush();
      word_valid = 1'b0;
      flush      = 1'b1;
      if (word_ready && cur.size() > 0) close_line();
      @(posedge clk);
      tick();
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cur.delete();
      exp_q.delete();
      model_lines = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitor: every strobe must match the oldest predicted line.
   initial begin
      logic [LINEW-1:0] e;
      logic [DATAW-1:0] x;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (chk_fill0) begin
               check("fill_after_pulse", fill_level, 0);
               chk_fill0 = 0;
            end
            if (instr_write_en) begin
               pulses++;
               pulse_cyc = cyc;
               last_line = line_out;
               check("ready_in_pulse", word_ready, 0);
               check("fill_in_pulse", fill_level, WORDS);
               check("pulse_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("line_out", line_out, e);
`ifdef INSTR_PACKER_CHECKSUM_EN
                  x = '0;
                  for (int k = 0; k < WORDS; k++) x = x ^ e[k*DATAW +: DATAW];
                  check("line_checksum", line_checksum, x);
`endif
               end
               chk_fill0 = 1;
            end
         end
      end
   end

   initial begin
      int p0;
      int unsigned a16, a17, drop_edge;
      logic [LINEW-1:0] snap;
      logic [DATAW-1:0] w;
      rst = 1'b1; word_in = '0; word_valid = 1'b0; flush = 1'b0; cache_stall = 1'b0;
      do_reset();
      check("rst_line_out", line_out, 0);
      check("rst_write_en", instr_write_en, 0);
      check("rst_fill", fill_level, 0);
      check("rst_count", line_count, 0);
      check("rst_ready", word_ready, 1);

      // lane order and minimum latency
      p0 = pulses;
      for (int i = 0; i < WORDS; i++) put(DATAW'(i), 0);
      idle();
      repeat (4) tick();
      check("t1_pulses", pulses - p0, 1);
      check("t1_latency", pulse_cyc, last_acc + 1);
      check("t1_lane0", last_line[31:0], 0);
      check("t1_lane15", last_line[511:480], 32'hF);
      check("t1_count", line_count, model_lines);

      // stall held in HOLD
      p0 = pulses;
      cache_stall = 1'b1;
      for (int i = 0; i < WORDS; i++) put($urandom, 0);
      idle();
      snap = line_out;
      for (int i = 0; i < 5; i++) begin
         check("stall_wen", instr_write_en, 0);
         check("stall_ready", word_ready, 0);
         check("stall_line", line_out, snap);
         tick();
      end
      cache_stall = 1'b0;
      drop_edge = cyc + 1;
      repeat (4) tick();
      check("stall_pulses", pulses - p0, 1);
      check("stall_release", pulse_cyc, drop_edge);

      // partial flush
      p0 = pulses;
      put(32'hAAAA_0001, 0); put(32'hBBBB_0002, 0); put(32'hCCCC_0003, 0);
      do_flush();
      check("flush_fill_hold", fill_level, WORDS);
      repeat (4) tick();
      check("flush_pulses", pulses - p0, 1);

      // empty flush, then flush together with the 16th word
      p0 = pulses;
      do_flush();
      repeat (4) tick();
      check("empty_flush_pulses", pulses - p0, 0);
      check("empty_flush_fill", fill_level, 0);
      for (int i = 0; i < WORDS - 1; i++) put($urandom, 0);
      w = $urandom;
      put(w, 1);
      idle();
      repeat (4) tick();
      check("simul_pulses", pulses - p0, 1);
      check("simul_lane15", last_line[511:480], w);

      // reset mid-fill discards the partial line
      for (int i = 0; i < 7; i++) put($urandom, 0);
      idle();
      do_reset();
      p0 = pulses;
      for (int i = 0; i < WORDS; i++) put($urandom, 0);
      idle();
      repeat (4) tick();
      check("rst_mid_pulses", pulses - p0, 1);
      check("rst_mid_count", line_count, 1);

      // back-to-back lines with valid held high
      do_reset();
      p0 = pulses;
      a16 = 0; a17 = 0;
      for (int i = 0; i < 2 * WORDS; i++) begin
         put($urandom, 0);
         if (i == WORDS - 1) a16 = last_acc;
         if (i == WORDS) a17 = last_acc;
      end
      idle();
      repeat (4) tick();
      check("b2b_pulses", pulses - p0, 2);
      check("b2b_gap", a17 - a16, 3);
      check("b2b_count", line_count, 2);

      // randomized traffic with random stalls and flushes
      rand_stall = 1;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0: begin idle(); tick(); end
            1: do_flush();
            default: put($urandom, $urandom_range(0, 11) == 0);
         endcase
      end
      idle();
      rand_stall = 0;
      cache_stall = 1'b0;
      repeat (4) tick();
      do_flush();
      repeat (6) tick();
      check("rand_drained", exp_q.size(), 0);
      check("rand_count", line_count, 16'(model_lines));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
